// File: rtl/io_responder_pkg.sv
// Shared definitions for the CPU I/O responder.
//   state_t        : responder FSM state encoding (2 bits)
//   WIDTH_DEF      : default data word width (matches accumulator)
//   DEPTH_LOG2_DEF : default log2 FIFO depth
package io_responder_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int DEPTH_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clock, reset : system clock, synchronous active-high reset
//   push, wdata  : write strobe and data (caller guarantees room, counting a same-cycle pop)
//   pop          : consume head word (never issued while empty)
//   rdata        : head word, valid whenever empty == 0
//   full, empty  : occupancy flags
//   count        : occupancy, 0 .. 2**DEPTH_LOG2
module sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // When full with push+pop together, wr_ptr == rd_ptr: the old head is
    // read combinationally this cycle and overwritten at the edge.
    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/io_responder.sv
// Device-side end of the CPU I/O syscall handshake.
//   clock, reset        : system clock, synchronous active-high reset
//   io_read, io_write   : CPU level requests, held until ioack is seen
//   io_wdata            : store data, valid while io_write is high
//   ioack, io_rdata     : four-phase acknowledge and load data
//   in_data/valid/ready : host input stream into the input FIFO
//   out_data/valid/ready: output FIFO head to the host (FWFT)
//   proto_err           : sticky; read and write requested together in IDLE
module io_responder
    import io_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [WIDTH-1:0] io_wdata,
    output logic             ioack,
    output logic [WIDTH-1:0] io_rdata,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             proto_err
);

    state_t           state_q, state_d;
    logic             ioack_d, err_d;
    logic [WIDTH-1:0] rdata_d;

    logic             in_push, in_pop, in_full, in_empty;
    logic [WIDTH-1:0] in_head;
    logic             out_push, out_pop, out_full, out_empty;
    logic [DEPTH_LOG2:0] unused_in_count, unused_out_count;

    assign in_push   = in_valid && in_ready;
    assign out_pop   = out_valid && out_ready;
    assign in_ready  = !in_full;
    assign out_valid = !out_empty;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_in_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_push),
        .wdata (in_data),
        .pop   (in_pop),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (unused_in_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_out_fifo (
        .clock (clock),
        .reset (reset),
        .push  (out_push),
        .wdata (io_wdata),
        .pop   (out_pop),
        .rdata (out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (unused_out_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ioack     <= 1'b0;
            io_rdata  <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ioack     <= ioack_d;
            io_rdata  <= rdata_d;
            proto_err <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ioack_d  = ioack;
        rdata_d  = io_rdata;
        err_d    = proto_err;
        in_pop   = 1'b0;
        out_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_read && io_write) err_d   = 1'b1;
                else if (io_read)        state_d = ST_RD_WAIT;
                else if (io_write)       state_d = ST_WR_WAIT;
            end
            ST_RD_WAIT: begin
                // A dropped request abandons the transaction with no FIFO access.
                if (!io_read) begin
                    state_d = ST_IDLE;
                end else if (!in_empty) begin
                    in_pop  = 1'b1;
                    rdata_d = in_head;
                    ioack_d = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_WR_WAIT: begin
                // A host pop this cycle frees a slot even when full.
                if (!io_write) begin
                    state_d = ST_IDLE;
                end else if (!out_full || out_pop) begin
                    out_push = 1'b1;
                    ioack_d  = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!(io_read || io_write)) begin
                    ioack_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;
    import io_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset, io_read, io_write, in_valid, out_ready;
    logic [15:0] io_wdata, in_data;
    logic        ioack, in_ready, out_valid, proto_err;
    logic [15:0] io_rdata, out_data;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [20];

    always #5 clock = ~clock;

    io_responder dut (
        .clock     (clock),
        .reset     (reset),
        .io_read   (io_read),
        .io_write  (io_write),
        .io_wdata  (io_wdata),
        .ioack     (ioack),
        .io_rdata  (io_rdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .proto_err (proto_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic host_push(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full STORE transaction with a bounded wait for ioack.
    task automatic do_write(input logic [15:0] v);
        io_write = 1'b1;
        io_wdata = v;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ioack) break;
        end
        chk("wr_ack", 16'(ioack), 16'd1);
        io_write = 1'b0;
        tick();
        chk("wr_ack_drop", 16'(ioack), 16'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h0001, 16'h0001}; vecs[1]  = '{16'hFFFF, 16'hFFFF};
        vecs[2]  = '{16'h8000, 16'h8000}; vecs[3]  = '{16'h0000, 16'h0000};
        vecs[4]  = '{16'hA5A5, 16'hA5A5}; vecs[5]  = '{16'h5A5A, 16'h5A5A};
        vecs[6]  = '{16'h1111, 16'h1111}; vecs[7]  = '{16'h2222, 16'h2222};
        vecs[8]  = '{16'h3333, 16'h3333}; vecs[9]  = '{16'h4444, 16'h4444};
        vecs[10] = '{16'hBEEF, 16'hBEEF}; vecs[11] = '{16'hCAFE, 16'hCAFE};
        vecs[12] = '{16'h0F0F, 16'h0F0F}; vecs[13] = '{16'hF0F0, 16'hF0F0};
        vecs[14] = '{16'h1357, 16'h1357}; vecs[15] = '{16'h2468, 16'h2468};
        vecs[16] = '{16'h7FFF, 16'h7FFF}; vecs[17] = '{16'h0100, 16'h0100};
        vecs[18] = '{16'hDEAD, 16'hDEAD}; vecs[19] = '{16'h4321, 16'h4321};

        reset = 1'b1; io_read = 1'b0; io_write = 1'b0; io_wdata = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_ioack", 16'(ioack), 16'd0);
        chk("rst_rdata", io_rdata, 16'h0000);
        chk("rst_err", 16'(proto_err), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        reset = 1'b0;

        // Read with data ready: ack two edges after io_read is raised.
        host_push(16'h1234);
        io_read = 1'b1;
        tick();
        chk("rd_ack_early", 16'(ioack), 16'd0);
        tick();
        chk("rd_ack", 16'(ioack), 16'd1);
        chk("rd_data", io_rdata, 16'h1234);
        chk("rd_in_ready", 16'(in_ready), 16'd1);
        tick();
        chk("rd_ack_hold", 16'(ioack), 16'd1);
        io_read = 1'b0;
        tick();
        chk("rd_ack_drop", 16'(ioack), 16'd0);
        chk("rd_data_keep", io_rdata, 16'h1234);

        // Read stall on empty input FIFO.
        io_read = 1'b1;
        begin
            int bad = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (ioack !== 1'b0) bad++;
            end
            chk("stall_no_ack", 16'(bad), 16'd0);
        end
        host_push(16'h00AB);
        chk("stall_push_edge", 16'(ioack), 16'd0);
        tick();
        chk("stall_ack", 16'(ioack), 16'd1);
        chk("stall_data", io_rdata, 16'h00AB);
        io_read = 1'b0;
        tick();

        // Write backpressure: 8 fill the output FIFO, the 9th waits.
        for (int v = 1; v <= 8; v++) do_write(16'(v));
        chk("wb_out_valid", 16'(out_valid), 16'd1);
        chk("wb_head", out_data, 16'h0001);
        io_write = 1'b1;
        io_wdata = 16'h0009;
        tick(); tick(); tick();
        chk("wb_full_no_ack", 16'(ioack), 16'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wb_pop_push_ack", 16'(ioack), 16'd1);
        chk("wb_head_after", out_data, 16'h0002);
        io_write = 1'b0;
        tick();
        chk("wb_ack_drop", 16'(ioack), 16'd0);
        for (int v = 2; v <= 9; v++) begin
            chk("drain_valid", 16'(out_valid), 16'd1);
            chk("drain_data", out_data, 16'(v));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_empty", 16'(out_valid), 16'd0);

        // Wrap-around through the input FIFO, table-driven.
        for (int i = 0; i < 20; i++) begin
            host_push(vecs[i].din);
            io_read = 1'b1;
            tick(); tick();
            chk("wrap_ack", 16'(ioack), 16'd1);
            chk("wrap_data", io_rdata, vecs[i].exp_rdata);
            io_read = 1'b0;
            tick();
        end
        chk("wrap_count", 16'(dut.u_in_fifo.count), 16'd0);

        // Simultaneous read and write in IDLE.
        host_push(16'h5555);
        io_read = 1'b1; io_write = 1'b1; io_wdata = 16'h6666;
        tick();
        chk("pe_err", 16'(proto_err), 16'd1);
        chk("pe_ioack", 16'(ioack), 16'd0);
        tick(); tick();
        chk("pe_ioack_hold", 16'(ioack), 16'd0);
        chk("pe_in_count", 16'(dut.u_in_fifo.count), 16'd1);
        chk("pe_out_valid", 16'(out_valid), 16'd0);
        io_read = 1'b0; io_write = 1'b0;
        tick();
        chk("pe_sticky", 16'(proto_err), 16'd1);
        io_read = 1'b1;
        tick(); tick();
        chk("pe_read_after", io_rdata, 16'h5555);
        io_read = 1'b0;
        tick();
        chk("pe_sticky2", 16'(proto_err), 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pe_rst_clear", 16'(proto_err), 16'd0);

        // Reset while in ACK with io_read held.
        host_push(16'h0777);
        host_push(16'h0888);
        io_read = 1'b1;
        tick(); tick();
        chk("ra_ack", 16'(ioack), 16'd1);
        chk("ra_data", io_rdata, 16'h0777);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ra_ioack", 16'(ioack), 16'd0);
        chk("ra_rdata", io_rdata, 16'h0000);
        chk("ra_count", 16'(dut.u_in_fifo.count), 16'd0);
        chk("ra_state", 16'(dut.state_q), 16'(ST_IDLE));
        host_push(16'h0999);
        chk("ra_fresh_wait", 16'(ioack), 16'd0);
        tick();
        chk("ra_fresh_ack", 16'(ioack), 16'd1);
        chk("ra_fresh_data", io_rdata, 16'h0999);
        io_read = 1'b0;
        tick();
        chk("ra_fresh_drop", 16'(ioack), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Device-side end of the CPU I/O syscall handshake: answers io_read/io_write requests from the CPU's I/O controller with ioack, using a four-phase handshake.
- Buffers the host input stream (bytes/words for LOAD syscalls) and the output stream (words from STORE syscalls) in small synchronous FIFOs.
- Sits between the CPU core and the board-level console/UART glue.

Parameters:
- DEPTH_LOG2, 3, log2 of each FIFO depth (8 entries by default).
- WIDTH, 16, data word width; matches the accumulator width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- io_read  in  1  CPU read request (LOAD); level, held until ioack seen.
- io_write  in  1  CPU write request (STORE); level, held until ioack seen.
- io_wdata  in  WIDTH  accumulator value; valid while io_write is high.
- ioack  out  1  acknowledge to the CPU.
- io_rdata  out  WIDTH  read data; stable whenever ioack is high after a read.
- in_data  in  WIDTH  host input word.
- in_valid  in  1  host input word valid.
- in_ready  out  1  input FIFO not full.
- out_data  out  WIDTH  output word to host (output FIFO head).
- out_valid  out  1  output FIFO not empty.
- out_ready  in  1  host accepts out_data.
- proto_err  out  1  sticky error flag; set when io_read and io_write are both high in IDLE.

Behaviour:
- Reset values: ioack=0, io_rdata=0, proto_err=0, both FIFOs empty (in_ready=1, out_valid=0), state=IDLE. Reset has the same effect mid-transaction, including when ioack is high.
- Host side:
  - Push to the input FIFO when in_valid && in_ready.
  - Pop from the output FIFO when out_valid && out_ready.
  - out_data is first-word-fall-through.
  - Push and pop in the same cycle are legal on each FIFO, including when full or empty. A push while full is blocked by in_ready=0. A pop-while-empty never occurs.
- State machine:
  - IDLE:
    - io_read only: go to RD_WAIT.
    - io_write only: go to WR_WAIT.
    - Both high: set proto_err, stay in IDLE, take no FIFO action; remain so until the pair changes.
  - RD_WAIT: when the input FIFO is non-empty, pop it, load io_rdata with the head word, set ioack=1, go to ACK. When the FIFO is already non-empty, ioack rises 2 cycles after io_read is first sampled high.
  - WR_WAIT: when the output FIFO is not full (counting a same-cycle host pop), push io_wdata sampled that cycle, set ioack=1, go to ACK.
  - ACK: hold ioack=1 and io_rdata. When io_read|io_write is sampled low, set ioack=0 and go to IDLE. A new request must first be seen low, so back-to-back transactions always pass through ioack=0.
- Request dropped in RD_WAIT or WR_WAIT before ack (protocol violation): abandon the transaction, return to IDLE, no FIFO action, no ack.
- Exactly one FIFO access per transaction regardless of how long the request is held.
- io_rdata keeps its last value outside transactions.
- FIFO pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits.
- CPU-side FIFO pop/push and host-side push/pop may coincide in one cycle.
  - Count = count + push - pop.
  - Full means count == 2^DEPTH_LOG2.

Decomposition:
- Shared package/header: state encodings ST_IDLE, ST_RD_WAIT, ST_WR_WAIT, ST_ACK (2 bits); WIDTH default.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH_LOG2; push/pop/full/empty/count, FWFT), instantiated twice.
- Responder FSM stays in io_responder.

Test Plan:
- Read with data ready: push 0x1234 on the host side, then hold io_read=1 → ioack=1 with io_rdata=0x1234 exactly 2 cycles later; drop io_read → ioack=0 next cycle; in_ready stays 1.
- Read stall: io_read=1 with the input FIFO empty for 10 cycles → ioack stays 0; push 0x00AB → ioack=1, io_rdata=0x00AB on the following cycle.
- Write backpressure: out_ready=0, 8 STORE transactions (0x0001..0x0008) complete. The 9th (0x0009) leaves ioack=0. Raise out_ready for one cycle → 0x0001 pops, 0x0009 is pushed, and ioack=1. Draining returns 0x0002..0x0009 in order.
- Wrap-around: 20 interleaved push/read pairs through the input FIFO → every io_rdata equals its pushed value; count returns to 0.
- Simultaneous io_read=io_write=1 in IDLE → proto_err=1, ioack=0, no FIFO count change; proto_err stays 1 until reset.
- Reset while in ACK with io_read=1 → next cycle ioack=0, FIFOs empty, state IDLE; io_read still high then begins a fresh transaction.
